serial_cmp_ctrl: RTL

Bit-serial magnitude comparator sequencer. It captures two WIDTH-bit operands on a start pulse, then walks them MSB-first through a single 1-bit equality slice, one bit per clock. It stops early at the first differing bit and reports eq/gt/lt plus the index of the first differing bit. It is the control layer above the 1-bit comparator datapath, letting one slice resolve full-width comparisons.

---
 rtl/serial_cmp_ctrl_pkg.sv | 17 +
 rtl/serial_cmp_ctrl_bit_eq_slice.sv | 11 +
 rtl/serial_cmp_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared constants for the bit-serial magnitude comparator: state encodings
// and the default operand width.
package serial_cmp_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_COMPARE = S_COMPARE,
    ST_DONE    = S_DONE
  } state_t;

endpackage

// File: rtl/serial_cmp_ctrl_bit_eq_slice.sv
// One-bit equality slice: the only datapath element the serial comparator
// walks its operands through.
module bit_eq_slice (
  input  logic x,
  input  logic y,
  output logic z
);

  assign z = ~(x ^ y);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator sequencer: captures two operands, walks
// them MSB-first through one equality slice and stops at the first mismatch.
module serial_cmp_ctrl
  import serial_cmp_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [IDXW-1:0]  diff_idx
);

  state_t            state, state_n;
  logic [WIDTH-1:0]  sa, sa_n;
  logic [WIDTH-1:0]  sb, sb_n;
  logic [IDXW-1:0]   cnt, cnt_n;
  logic [IDXW-1:0]   idx_n;
  logic              busy_n, done_n, eq_n, gt_n, lt_n;
  logic              bit_eq;

  bit_eq_slice u_slice (
    .x (sa[WIDTH-1]),
    .y (sb[WIDTH-1]),
    .z (bit_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sa       <= '0;
      sb       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      diff_idx <= '0;
    end else begin
      state    <= state_n;
      sa       <= sa_n;
      sb       <= sb_n;
      cnt      <= cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      eq       <= eq_n;
      gt       <= gt_n;
      lt       <= lt_n;
      diff_idx <= idx_n;
    end
  end

  // Results hold their last value outside COMPARE so they stay readable
  // after the single-cycle done pulse.
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    cnt_n   = cnt;
    eq_n    = eq;
    gt_n    = gt;
    lt_n    = lt;
    idx_n   = diff_idx;
    done_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          sa_n    = a;
          sb_n    = b;
          cnt_n   = IDXW'(WIDTH - 1);
          state_n = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        if (bit_eq) begin
          if (cnt != '0) begin
            sa_n  = {sa[WIDTH-2:0], 1'b0};
            sb_n  = {sb[WIDTH-2:0], 1'b0};
            cnt_n = cnt - IDXW'(1);
          end else begin
            eq_n    = 1'b1;
            gt_n    = 1'b0;
            lt_n    = 1'b0;
            idx_n   = '0;
            done_n  = 1'b1;
            state_n = ST_DONE;
          end
        end else begin
          // At a mismatch the operand holding the 1 is the larger one.
          eq_n    = 1'b0;
          gt_n    = sa[WIDTH-1];
          lt_n    = ~sa[WIDTH-1];
          idx_n   = cnt;
          done_n  = 1'b1;
          state_n = ST_DONE;
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule
